// File: rtl/sys_arr_ctrl_if.sv
// Control/handshake bundle between the systolic-array controller and the
// surrounding datapath (operand buffers, PE array, result consumer).
interface sys_arr_ctrl_if #(
  parameter int N  = 4,
  parameter int KW = 8
);
  localparam int DW = (N > 1) ? $clog2(N) : 1;

  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          buf_rd_en;
  logic [KW-1:0] buf_rd_addr;
  logic [N-1:0]  row_vld;
  logic [N-1:0]  col_vld;
  logic          pe_clr;
  logic [6:0]    dsp_conf;
  logic [DW-1:0] drain_sel;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    err_in;
  logic [1:0]    err_out;

  // Controller side
  modport slave (
    input  start, k_len, out_ready, err_in,
    output busy, done, buf_rd_en, buf_rd_addr, row_vld, col_vld,
           pe_clr, dsp_conf, drain_sel, out_valid, err_out
  );

  // Requester / datapath side
  modport master (
    output start, k_len, out_ready, err_in,
    input  busy, done, buf_rd_en, buf_rd_addr, row_vld, col_vld,
           pe_clr, dsp_conf, drain_sel, out_valid, err_out
  );
endinterface

// File: rtl/sys_arr_ctrl.sv
// Tile sequencer for an NxN output-stationary systolic array of DSP MAC PEs.
// Sequence per tile: CLEAR accumulators, LOAD k_len operand pairs, FLUSH the
// skew + MAC pipeline, DRAIN one result row per accepted transfer, DONE pulse.
// Every output is a flop; next-state outputs are decoded from state_d so the
// registered outputs line up with the state they belong to.
module sys_arr_ctrl #(
  parameter int N   = 4,
  parameter int KW  = 8,
  parameter int LAT = 4
) (
  input logic           clk,
  input logic           rst,
  sys_arr_ctrl_if.slave bus
);

  localparam int DW = (N > 1) ? $clog2(N) : 1;
  // Flush length: 1 cycle buffer read latency + 2N-2 skew + MAC latency
  localparam int F  = 2 * N - 1 + LAT;
  localparam int CW = $clog2(F + 1);

  localparam logic [6:0]    CONF_MAC = 7'b0010001;
  localparam logic [6:0]    CONF_NA  = 7'b0000000;
  localparam logic [CW-1:0] F_LAST   = CW'(F - 1);
  localparam logic [DW-1:0] SEL_LAST = DW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] sel_q, sel_d;
  logic [1:0]    err_q, err_d;
  logic [N-1:0]  vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic          pe_clr_q, pe_clr_d;
  logic          oval_q, oval_d;
  logic [6:0]    conf_q, conf_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          k_len_d = bus.k_len;
          // Error flags belong to one tile; zero them as CLEAR is entered
          err_d   = 2'b00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (k_len_q != {KW{1'b0}}) begin
          state_d = S_LOAD;
          addr_d  = {KW{1'b0}};
        end else begin
          state_d = S_DRAIN;
          sel_d   = {DW{1'b0}};
        end
      end
      S_LOAD: begin
        err_d = err_q | bus.err_in;
        if (addr_q == (k_len_q - KW'(1))) begin
          state_d = S_FLUSH;
          addr_d  = {KW{1'b0}};
          cnt_d   = F_LAST;
        end else begin
          addr_d  = addr_q + KW'(1);
        end
      end
      S_FLUSH: begin
        err_d = err_q | bus.err_in;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_DRAIN;
          sel_d   = {DW{1'b0}};
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (sel_q == SEL_LAST) begin
            state_d = S_DONE;
            sel_d   = {DW{1'b0}};
          end else begin
            sel_d   = sel_q + DW'(1);
          end
        end else begin
          sel_d = sel_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    rd_en_d  = (state_d == S_LOAD);
    pe_clr_d = (state_d == S_CLEAR);
    oval_d   = (state_d == S_DRAIN);
    if ((state_d == S_LOAD) || (state_d == S_FLUSH)) begin
      conf_d = CONF_MAC;
    end else begin
      conf_d = CONF_NA;
    end

    // Skew line: tap i is the read strobe delayed by 1+i cycles; it runs in
    // every state so trailing valids drain out naturally during FLUSH.
    vld_d = N'({vld_q, rd_en_q});
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_len_q  <= {KW{1'b0}};
      addr_q   <= {KW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      sel_q    <= {DW{1'b0}};
      err_q    <= 2'b00;
      vld_q    <= {N{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      pe_clr_q <= 1'b0;
      oval_q   <= 1'b0;
      conf_q   <= CONF_NA;
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      pe_clr_q <= pe_clr_d;
      oval_q   <= oval_d;
      conf_q   <= conf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.buf_rd_en   = rd_en_q;
  assign bus.buf_rd_addr = addr_q;
  assign bus.row_vld     = vld_q;
  assign bus.col_vld     = vld_q;
  assign bus.pe_clr      = pe_clr_q;
  assign bus.dsp_conf    = conf_q;
  assign bus.drain_sel   = sel_q;
  assign bus.out_valid   = oval_q;
  assign bus.err_out     = err_q;

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// Directed bench for sys_arr_ctrl (N=4, KW=8, LAT=4, so flush length 11).
// Cycle k is the interval after the k-th observed rising edge; outputs are
// sampled 1 time unit after the edge and inputs are driven at the same point.
module tb_sys_arr_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total    = 0;

  sys_arr_ctrl_if #(.N(4), .KW(8)) bus_if ();

  sys_arr_ctrl #(.N(4), .KW(8), .LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(bus_if.busy), 32'd0);
    chk({tag, "_done"},  32'(bus_if.done), 32'd0);
    chk({tag, "_rden"},  32'(bus_if.buf_rd_en), 32'd0);
    chk({tag, "_addr"},  32'(bus_if.buf_rd_addr), 32'd0);
    chk({tag, "_row"},   32'(bus_if.row_vld), 32'd0);
    chk({tag, "_col"},   32'(bus_if.col_vld), 32'd0);
    chk({tag, "_clr"},   32'(bus_if.pe_clr), 32'd0);
    chk({tag, "_oval"},  32'(bus_if.out_valid), 32'd0);
    chk({tag, "_sel"},   32'(bus_if.drain_sel), 32'd0);
    chk({tag, "_err"},   32'(bus_if.err_out), 32'd0);
    chk({tag, "_conf"},  32'(bus_if.dsp_conf), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_row;
    logic       exp_en;

    rst              = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.k_len     = 8'd0;
    bus_if.out_ready = 1'b1;
    bus_if.err_in    = 2'b00;
    tick();
    tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // ---- Tile 1: k_len=3, error injected in FLUSH ----
    bus_if.start = 1'b1;
    bus_if.k_len = 8'd3;
    chk("t1_c0_busy", 32'(bus_if.busy), 32'd0);
    tick();
    bus_if.start = 1'b0;
    chk("t1_c1_clr",  32'(bus_if.pe_clr), 32'd1);
    chk("t1_c1_busy", 32'(bus_if.busy), 32'd1);
    chk("t1_c1_conf", 32'(bus_if.dsp_conf), 32'd0);
    for (int c = 2; c <= 21; c++) begin
      tick();
      exp_en = (c >= 2) && (c <= 4);
      for (int i = 0; i < 4; i++) exp_row[i] = (c >= 3 + i) && (c <= 5 + i);
      chk($sformatf("t1_c%0d_rden", c), 32'(bus_if.buf_rd_en), 32'(exp_en));
      chk($sformatf("t1_c%0d_addr", c), 32'(bus_if.buf_rd_addr), exp_en ? 32'(c - 2) : 32'd0);
      chk($sformatf("t1_c%0d_row", c),  32'(bus_if.row_vld), 32'(exp_row));
      chk($sformatf("t1_c%0d_col", c),  32'(bus_if.col_vld), 32'(exp_row));
      chk($sformatf("t1_c%0d_clr", c),  32'(bus_if.pe_clr), 32'd0);
      chk($sformatf("t1_c%0d_conf", c), 32'(bus_if.dsp_conf), ((c >= 2) && (c <= 15)) ? 32'h11 : 32'h00);
      chk($sformatf("t1_c%0d_oval", c), 32'(bus_if.out_valid), 32'((c >= 16) && (c <= 19)));
      chk($sformatf("t1_c%0d_sel", c),  32'(bus_if.drain_sel), ((c >= 16) && (c <= 19)) ? 32'(c - 16) : 32'd0);
      chk($sformatf("t1_c%0d_done", c), 32'(bus_if.done), 32'(c == 20));
      chk($sformatf("t1_c%0d_busy", c), 32'(bus_if.busy), 32'(c <= 20));
      chk($sformatf("t1_c%0d_err", c),  32'(bus_if.err_out), (c >= 11) ? 32'd2 : 32'd0);
      bus_if.err_in = (c == 10) ? 2'b10 : 2'b00;
    end

    // ---- Tile 2: k_len=2, consumer stalls 5 cycles at drain_sel=2 ----
    // Cycle 0 is the IDLE cycle with start; DRAIN starts at cycle 15.
    bus_if.start = 1'b1;
    bus_if.k_len = 8'd2;
    chk("t2_c0_err_held", 32'(bus_if.err_out), 32'd2);
    tick();
    bus_if.start = 1'b0;
    chk("t2_c1_clr", 32'(bus_if.pe_clr), 32'd1);
    chk("t2_c1_err_cleared", 32'(bus_if.err_out), 32'd0);
    for (int c = 2; c <= 17; c++) tick();
    chk("t2_c17_sel", 32'(bus_if.drain_sel), 32'd2);
    chk("t2_c17_oval", 32'(bus_if.out_valid), 32'd1);
    bus_if.out_ready = 1'b0;
    for (int c = 18; c <= 22; c++) begin
      tick();
      chk($sformatf("t2_c%0d_hold_sel", c), 32'(bus_if.drain_sel), 32'd2);
      chk($sformatf("t2_c%0d_hold_oval", c), 32'(bus_if.out_valid), 32'd1);
      chk($sformatf("t2_c%0d_hold_done", c), 32'(bus_if.done), 32'd0);
    end
    bus_if.out_ready = 1'b1;
    tick();
    chk("t2_c23_sel", 32'(bus_if.drain_sel), 32'd3);
    tick();
    chk("t2_c24_done", 32'(bus_if.done), 32'd1);
    chk("t2_c24_oval", 32'(bus_if.out_valid), 32'd0);
    tick();

    // ---- Tile 3: k_len=0 goes straight from CLEAR to DRAIN ----
    bus_if.start = 1'b1;
    bus_if.k_len = 8'd0;
    tick();
    bus_if.start = 1'b0;
    chk("t3_c1_clr", 32'(bus_if.pe_clr), 32'd1);
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk($sformatf("t3_c%0d_rden", c), 32'(bus_if.buf_rd_en), 32'd0);
      chk($sformatf("t3_c%0d_conf", c), 32'(bus_if.dsp_conf), 32'd0);
      chk($sformatf("t3_c%0d_oval", c), 32'(bus_if.out_valid), 32'((c >= 2) && (c <= 5)));
      chk($sformatf("t3_c%0d_sel", c),  32'(bus_if.drain_sel), ((c >= 2) && (c <= 5)) ? 32'(c - 2) : 32'd0);
      chk($sformatf("t3_c%0d_done", c), 32'(bus_if.done), 32'(c == 6));
    end

    // ---- Tile 4: reset in LOAD at address 5, then a normal k_len=1 tile ----
    bus_if.start = 1'b1;
    bus_if.k_len = 8'd10;
    tick();
    bus_if.start = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    chk("t4_c7_addr", 32'(bus_if.buf_rd_addr), 32'd5);
    chk("t4_c7_row", 32'(bus_if.row_vld), 32'hF);
    rst = 1'b1;
    tick();
    chk_reset_vals("t4_abort");
    rst = 1'b0;
    bus_if.start = 1'b1;
    bus_if.k_len = 8'd1;
    tick();
    bus_if.start = 1'b0;
    chk("t4_restart_clr", 32'(bus_if.pe_clr), 32'd1);
    // Done expected 1+1+11+4+1 = 18 cycles after the start cycle
    for (int c = 2; c <= 19; c++) begin
      tick();
      chk($sformatf("t4_c%0d_done", c), 32'(bus_if.done), 32'(c == 18));
    end

    // ---- Tile 5: start held high, back-to-back k_len=0 tiles ----
    bus_if.start = 1'b1;
    bus_if.k_len = 8'd0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("t5_c%0d_clr", c),  32'(bus_if.pe_clr), 32'((c == 1) || (c == 8)));
      chk($sformatf("t5_c%0d_busy", c), 32'(bus_if.busy), 32'(c != 7));
      chk($sformatf("t5_c%0d_done", c), 32'(bus_if.done), 32'(c == 6));
    end
    bus_if.start = 1'b0;
    for (int c = 9; c <= 14; c++) begin
      tick();
      chk($sformatf("t5_c%0d_done", c), 32'(bus_if.done), 32'(c == 13));
      chk($sformatf("t5_c%0d_busy", c), 32'(bus_if.busy), 32'(c <= 13));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/sys_arr_ctrl.md
SYS_ARR_CTRL -- requirements
Module: sys_arr_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension (NxN DSP MAC PEs, output-stationary).
REQ-002 Parameter KW, default 8: width of the k_len and buf_rd_addr ports.
REQ-003 Parameter LAT, default 4: DSP MAC pipeline latency, in cycles.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request a tile; sampled only in IDLE.
REQ-007 k_len  in  KW  MAC steps in the reduction; sampled with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse on tile completion.
REQ-010 buf_rd_en  out  1  operand A/B buffer read strobe; buffer read latency is 1 cycle.
REQ-011 buf_rd_addr  out  KW  operand buffer read address.
REQ-012 row_vld  out  N  per-row A-operand valid, skewed.
REQ-013 col_vld  out  N  per-column B-operand valid, skewed.
REQ-014 pe_clr  out  1  clears every PE accumulator and its dirty bit.
REQ-015 dsp_conf  out  7  DSP adder config: MAC=7'b0010001 or NA=7'b0000000.
REQ-016 drain_sel  out  clog2(N)  result row being drained.
REQ-017 out_valid  out  1  drained row available.
REQ-018 out_ready  in  1  consumer accepts the drained row.
REQ-019 err_in  in  2  {overflow, underflow} ORed across the array.
REQ-020 err_out  out  2  sticky {overflow, underflow} for the current tile.

Function
REQ-021 The FSM SHALL have the states IDLE, CLEAR, LOAD, FLUSH, DRAIN and DONE.
REQ-022 IDLE->CLEAR when start=1; k_len latched; start in any other state ignored.
REQ-023 CLEAR lasts 1 cycle: pe_clr=1, err_out cleared; then ->LOAD if k_len!=0, else ->DRAIN.
REQ-024 LOAD lasts exactly k_len cycles: buf_rd_en=1, buf_rd_addr counts 0..k_len-1 (no wrap; max 2^KW-1).
REQ-025 row_vld[i] SHALL equal buf_rd_en delayed 1+i cycles; col_vld[j] the same with j; delay lines keep shifting in every state and are flushed to 0 only by rst.
REQ-026 FLUSH lasts F=2N-1+LAT cycles (read latency + max skew 2N-2 + LAT), counted by a down-counter, then ->DRAIN.
REQ-027 dsp_conf=MAC in LOAD and FLUSH, NA in every other state.
REQ-028 In DRAIN: out_valid=1, drain_sel starts at 0 and increments on each cycle with out_valid&out_ready; the transfer at drain_sel=N-1 moves the FSM to DONE.
REQ-029 While out_ready=0 in DRAIN, drain_sel and out_valid SHALL hold.
REQ-030 DONE lasts 1 cycle: done=1, busy=1; then ->IDLE, and start can be accepted on the next cycle.
REQ-031 err_out SHALL OR in err_in every cycle in LOAD or FLUSH, hold in all other states, and clear only in CLEAR or on rst.
REQ-032 Latency from the start-sampling edge to done (out_ready held 1): 1+k_len+F+N cycles until DONE is entered; done is high in the cycle after the last drain transfer.

Reset
REQ-033 rst=1 at any clock edge SHALL force IDLE and zero busy, done, buf_rd_en, buf_rd_addr, row_vld, col_vld, pe_clr, out_valid, drain_sel and err_out, and set dsp_conf=NA.
REQ-034 Reset mid-tile (any state) SHALL abort the tile with no done pulse; start is accepted from the first cycle after rst deasserts.

Verification
REQ-035 N=4, LAT=4, k_len=3, out_ready=1, start pulsed, taking cycle 0 as the first IDLE cycle with start=1 -> pe_clr high in cycle 1; buf_rd_en in cycles 2-4 with addresses 0,1,2; row_vld[3] high in cycles 6-8; FLUSH in cycles 5-15; out_valid in cycles 16-19 with drain_sel 0..3; done in cycle 20.
REQ-036 k_len=0 -> CLEAR, then DRAIN directly; no buf_rd_en, dsp_conf stays NA, and done follows N drain transfers.
REQ-037 out_ready=0 for 5 cycles at drain_sel=2 -> drain_sel holds at 2 and out_valid stays 1; the sequence resumes when out_ready=1.
REQ-038 err_in=2'b10 for 1 cycle in FLUSH -> err_out=2'b10 through DONE; the next start clears it in CLEAR.
REQ-039 rst asserted in LOAD at buf_rd_addr=5 -> next cycle IDLE with all outputs at reset values; no done; a start immediately after rst runs a normal tile.
REQ-040 start held high continuously -> back-to-back tiles, one IDLE cycle between the DONE cycle and the next CLEAR; start during busy has no effect.
